// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: state encoding and stream constants shared by the loader
package imem_loader_pkg;
  localparam int HDR_BYTES = 2;
  localparam int CSUM_W = 8;
  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } loader_state_t;
endpackage

// File: rtl/imem_loader.sv
// imem_loader: length-prefixed checksummed byte stream to imem byte writes, holding the core while loading
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);
  loader_state_t state, state_n;
  logic [15:0] cnt, len, n;
  logic [CSUM_W-1:0] sum;
  logic acc, rest, go, data_acc;
  assign acc = in_valid && in_ready;
  assign rest = state == S_IDLE || state == S_DONE || state == S_ERR;
  assign go = rest && start;
  assign data_acc = state == S_DATA && acc;
  assign n = {len[15:8], in_data};
  assign in_ready = state == S_LEN_HI || state == S_LEN_LO || state == S_DATA || state == S_CSUM;
  assign cpu_hold = in_ready || state == S_ERR;
  assign done = state == S_DONE;
  assign err = state == S_ERR;
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: state_n = start ? S_LEN_HI : state;
      S_LEN_HI: state_n = acc ? S_LEN_LO : state;
      S_LEN_LO: state_n = !acc ? state : ({1'b0, n} > 17'(MEM_BYTES)) ? S_ERR : (n == 16'd0) ? S_CSUM : S_DATA;
      S_DATA: state_n = (acc && cnt == len - 16'd1) ? S_CSUM : state;
      S_CSUM: state_n = !acc ? state : (in_data == sum) ? S_DONE : S_ERR;
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt <= '0;
      len <= '0;
      sum <= '0;
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      state <= state_n;
      wr_en <= data_acc;
      if (data_acc) begin
        wr_addr <= cnt[ADDR_W-1:0];
        wr_data <= in_data;
        cnt <= cnt + 16'd1;
        sum <= sum + in_data;
      end
      if (state == S_LEN_HI && acc) len[15:8] <= in_data;
      if (state == S_LEN_LO && acc) len[7:0] <= in_data;
      if (go) begin
        cnt <= '0;
        sum <= '0;
      end
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader
module tb_imem_loader;
  logic clk = 0, rst_n = 0, start = 0, in_valid = 0;
  logic [7:0] in_data = 0;
  logic in_ready, wr_en, cpu_hold, done, err;
  logic [9:0] wr_addr;
  logic [7:0] wr_data;
  int nvec = 0, nerr = 0, cyc = 0;
  int wa[$], wd[$], wc[$], wdone[$];
  int exp_d[4] = '{8'h00, 8'h40, 8'h00, 8'h6f};
  imem_loader #(.MEM_BYTES(1024), .ADDR_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (wr_en) begin
    wa.push_back(int'(wr_addr));
    wd.push_back(int'(wr_data));
    wc.push_back(cyc);
    wdone.push_back(int'(done));
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic clear_log();
    wa.delete();
    wd.delete();
    wc.delete();
    wdone.delete();
  endtask
  task automatic pulse_start();
    start = 1;
    tick(1);
    start = 0;
  endtask
  task automatic send(input logic [7:0] b);
    int t = 0;
    in_valid = 1;
    in_data = b;
    while (!in_ready && t < 50) begin
      tick(1);
      t++;
    end
    if (!in_ready) check("send_timeout", 32'd1, 32'd0);
    else tick(1);
    in_valid = 0;
  endtask
  task automatic check_basic_writes(input string tag, input bit b2b);
    check({tag, "_nwr"}, wa.size(), 4);
    if (wa.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check({tag, "_addr"}, wa[i], i);
        check({tag, "_data"}, wd[i], exp_d[i]);
        check({tag, "_done_during_wr"}, wdone[i], 0);
      end
      if (b2b) check({tag, "_b2b"}, wc[3] - wc[0], 3);
    end
  endtask
  initial begin
    int bad;
    tick(2);
    check("rst_outs", {in_ready, wr_en, cpu_hold, done, err}, 0);
    check("rst_addr_data", {wr_addr, wr_data}, 0);
    rst_n = 1;
    tick(2);
    check("idle_outs", {in_ready, cpu_hold, done, err}, 0);
    // basic load
    clear_log();
    pulse_start();
    check("start_ready_hold", {in_ready, cpu_hold}, 2'b11);
    send(8'h00); send(8'h04);
    send(8'h00); send(8'h40); send(8'h00); send(8'h6f);
    check("basic_hold_in_csum", {in_ready, cpu_hold, done}, 3'b110);
    send(8'haf);
    tick(2);
    check_basic_writes("basic", 1);
    check("basic_status", {done, err, cpu_hold, in_ready}, 4'b1000);
    // bad checksum
    clear_log();
    pulse_start();
    check("restart_clears_done", done, 0);
    send(8'h00); send(8'h04);
    send(8'h00); send(8'h40); send(8'h00); send(8'h6f);
    send(8'h00);
    tick(2);
    check_basic_writes("badcs", 0);
    check("badcs_status", {done, err, cpu_hold, in_ready}, 4'b0110);
    // over-length
    clear_log();
    pulse_start();
    check("err_cleared", err, 0);
    send(8'h04); send(8'h01);
    check("ovl_status", {done, err, cpu_hold, in_ready}, 4'b0110);
    in_valid = 1;
    in_data = 8'h55;
    tick(3);
    in_valid = 0;
    tick(1);
    check("ovl_nwr", wa.size(), 0);
    check("ovl_stays_err", {err, in_ready}, 2'b10);
    // exactly MEM_BYTES, bytes i mod 256, checksum 0
    clear_log();
    pulse_start();
    send(8'h04); send(8'h00);
    for (int i = 0; i < 1024; i++) send(8'(i));
    send(8'h00);
    tick(2);
    check("full_nwr", wa.size(), 1024);
    bad = 0;
    for (int i = 0; i < wa.size(); i++) if (wa[i] != i || wd[i] != (i % 256)) bad++;
    check("full_contents", bad, 0);
    if (wa.size() > 0) check("full_last_addr", wa[wa.size()-1], 1023);
    check("full_status", {done, err, cpu_hold}, 3'b100);
    // zero length
    clear_log();
    pulse_start();
    send(8'h00); send(8'h00);
    check("zero_in_csum", {in_ready, cpu_hold}, 2'b11);
    send(8'h00);
    tick(2);
    check("zero_nwr", wa.size(), 0);
    check("zero_status", {done, err, cpu_hold}, 3'b100);
    // backpressure gaps and start pulse mid-DATA
    clear_log();
    pulse_start();
    send(8'h00); tick(2); send(8'h04); tick(1);
    send(8'h00); tick(3); send(8'h40);
    pulse_start();
    check("mid_start_ignored", {in_ready, cpu_hold}, 2'b11);
    send(8'h00); tick(1); send(8'h6f); tick(2);
    send(8'haf);
    tick(2);
    check_basic_writes("bp", 0);
    check("bp_status", {done, err, cpu_hold}, 3'b100);
    pulse_start();
    check("reload_from_done", {done, in_ready, cpu_hold}, 3'b011);
    // reset mid-load, then a clean load
    send(8'h00); send(8'h04); send(8'h00); send(8'h40);
    #3 rst_n = 0;
    #1;
    check("async_rst_outs", {in_ready, wr_en, cpu_hold, done, err}, 0);
    check("async_rst_addr_data", {wr_addr, wr_data}, 0);
    tick(1);
    rst_n = 1;
    tick(1);
    check("post_rst_idle", {in_ready, cpu_hold}, 0);
    clear_log();
    pulse_start();
    send(8'h00); send(8'h04);
    send(8'h00); send(8'h40); send(8'h00); send(8'h6f);
    send(8'haf);
    tick(2);
    check_basic_writes("after_rst", 1);
    check("after_rst_status", {done, err, cpu_hold}, 3'b100);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
